time_bcd_counter: RTL and testbench
===================================

# time_bcd_counter

Upstream of the `num` seven-segment scan stage: keeps a 24-hour HH-MM-SS time of day in BCD and presents it as eight packed digit codes for the scanner to multiplex onto `num`/`DS`. Advances on a one-cycle `tick` strobe taken from the `clk_divide` output, gated by `en_all`. Supports setting hours and minutes from two pre-debounced keys, and outputs a blink mask for the field being edited.

## Interface
- `DASH_CODE`, default 4'hA: digit code for the separator positions; the scanner renders it as "-".
- `clk` in 1: system clock, 1 MHz in the board bench.
- `rst` in 1: reset, synchronous, active-high.
- `en_all` in 1: global enable. When 0, all state is frozen and `tick`, `key_mode` and `key_inc` are ignored.
- `tick` in 1: one-cycle 1 Hz strobe.
- `key_mode` in 1: one-cycle pulse that steps the mode.
- `key_inc` in 1: one-cycle pulse that increments the field being edited.
- `digits` out 32: eight 4-bit codes.
  - [31:28] H tens, [27:24] H ones, [23:20] DASH, [19:16] M tens.
  - [15:12] M ones, [11:8] DASH, [7:4] S tens, [3:0] S ones.
- `blank_mask` out 8: one bit per digit position; 1 means the scanner blanks that digit.
- `day_pulse` out 1: one-cycle pulse on the 23:59:59 to 00:00:00 rollover.
- `mode` out 2: current mode (0 RUN, 1 SET_H, 2 SET_M).

## Operation
- Reset values:
  - time 00:00:00, so `digits` = 32'h00A00A00.
  - `mode` RUN, `blank_mask` 0, `day_pulse` 0, blink phase 0.
- Mode FSM, advanced only when `en_all`=1 and `key_mode`=1:
  - RUN to SET_H.
  - SET_H to SET_M.
  - SET_M to RUN.
- RUN mode:
  - Each tick increments seconds.
  - Seconds wrap 59 to 00 and carry into minutes.
  - Minutes wrap 59 to 00 and carry into hours.
  - Hours wrap 23 to 00 and assert `day_pulse`.
  - `key_inc` is ignored.
- Entering SET_H from RUN: clear seconds to 00.
- SET_H and SET_M: time does not advance on `tick`.
- `key_inc` in SET_H: hours increment, 23 wraps to 00.
- `key_inc` in SET_M: minutes increment, 59 wraps to 00.
- No carry between fields and no `day_pulse` in either SET mode.
- Blink:
  - The blink phase toggles on each `tick` in SET modes.
  - The phase is forced to 0 on every mode change and on every `key_inc`.
  - `blank_mask` = 8'b1100_0000 (SET_H) or 8'b0001_1000 (SET_M) while the phase is 1, otherwise 0.
  - `blank_mask` is always 0 in RUN.
- Arithmetic is per-digit BCD:
  - A ones digit at 9 goes to 0 and increments the tens digit.
  - Field limits are compared on the full two-digit value.
  - Digits never hold codes above 9.
- Simultaneous events (all require `en_all`=1):
  - `key_mode` together with `key_inc`: the mode change wins and the increment is dropped.
  - `key_mode` together with `tick` in RUN: the mode change wins, the tick is dropped and seconds clear to 00.
  - `key_inc` together with `tick` in a SET mode: the increment applies and the blink phase goes to 0.

## Timing
- All outputs are registered. `digits`, `blank_mask` and `mode` update on the edge after the qualifying input cycle, so latency is 1 cycle.
- `day_pulse` is high for exactly the cycle in which `digits` first shows 00:00:00.
- `rst` has priority over `en_all` and over all events. Asserting it mid-set returns to RUN at 00:00:00 on the next edge.
- Inputs are assumed to be one-cycle pulses. A held level counts as one event per cycle; no edge detection is done here.

## Structure
- Shared package `clock_pkg`:
  - mode encoding constants RUN/SET_H/SET_M.
  - `DASH_CODE` default.
  - field bit-slice constants for `digits`.
  - `blank_mask` field patterns.
- Sub-module `bcd_mod_counter`:
  - Two-digit BCD counter with parameter MAX (59 or 23).
  - Inputs `clk`, `rst`, `inc`, `clr`; outputs `tens`, `ones`, `wrap`.
  - `wrap` is combinational: high when `inc` arrives at MAX.
  - Instantiated three times: seconds, minutes, hours.
- The top level holds the mode FSM, the blink phase, carry gating and output packing.

## Test plan
- Reset, then `en_all`=1 and 61 ticks in RUN: `digits`=32'h00A01A01, `day_pulse` never high.
- Preload 23:59:58 via SET keys, return to RUN, 2 ticks: second tick gives 32'h00A00A00 with `day_pulse` high for exactly one cycle.
- RUN at 00:00:37, `key_mode`: `mode`=1, seconds 00. Then 25 `key_inc`: hours 01. Then `key_mode`, 60 `key_inc`: minutes 00, hours still 01.
- SET_M with ticks: `blank_mask` alternates 8'h00 / 8'h18 per tick. A `key_inc` forces 8'h00 next cycle. Time does not advance.
- `en_all`=0 with ticks and keys for 100 cycles: all outputs constant. `key_mode`+`key_inc` in the same cycle in SET_H: mode goes to SET_M and hours are unchanged.
- `rst` pulse in SET_H with blink phase 1: next cycle `mode`=0, `digits`=32'h00A00A00, `blank_mask`=0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants for the BCD time-of-day counter: mode encoding, digit slices, blink patterns.
package clock_pkg;

  typedef enum logic [1:0] {
    ModeRun  = 2'd0,
    ModeSetH = 2'd1,
    ModeSetM = 2'd2
  } mode_e;

  localparam logic [3:0] DashCodeDefault = 4'hA;

  // Bit offsets of each 4-bit code within the packed digits word
  localparam int unsigned HrTensLsb  = 28;
  localparam int unsigned HrOnesLsb  = 24;
  localparam int unsigned DashHiLsb  = 20;
  localparam int unsigned MinTensLsb = 16;
  localparam int unsigned MinOnesLsb = 12;
  localparam int unsigned DashLoLsb  = 8;
  localparam int unsigned SecTensLsb = 4;
  localparam int unsigned SecOnesLsb = 0;

  localparam logic [7:0] BlankSetH = 8'b1100_0000;
  localparam logic [7:0] BlankSetM = 8'b0001_1000;
  localparam logic [7:0] BlankNone = 8'b0000_0000;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps from MAX to 00; wrap flags the increment that wraps.
module bcd_mod_counter #(
  parameter int unsigned MAX = 59
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_inc,
  input  logic       i_clr,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic       o_wrap
);

  localparam logic [3:0] MaxTens = 4'(MAX / 10);
  localparam logic [3:0] MaxOnes = 4'(MAX % 10);

  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic       w_at_max;

  assign w_at_max = (r_tens == MaxTens) && (r_ones == MaxOnes);
  assign o_wrap   = i_inc && !i_clr && w_at_max;
  assign o_tens   = r_tens;
  assign o_ones   = r_ones;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (i_inc) begin
      if (w_at_max) begin
        r_tens <= 4'd0;
        r_ones <= 4'd0;
      end else if (r_ones == 4'd9) begin
        r_tens <= r_tens + 4'd1;
        r_ones <= 4'd0;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_bcd_counter.sv
// 24-hour HH-MM-SS BCD clock with hour/minute set modes, blink mask and day rollover pulse.
module time_bcd_counter
  import clock_pkg::*;
#(
  parameter logic [3:0] DASH_CODE = DashCodeDefault
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en_all,
  input  logic        i_tick,
  input  logic        i_key_mode,
  input  logic        i_key_inc,
  output logic [31:0] o_digits,
  output logic [7:0]  o_blank_mask,
  output logic        o_day_pulse,
  output logic [1:0]  o_mode
);

  mode_e r_mode;
  logic  r_blink;
  logic  r_day_pulse;

  logic w_ev_mode, w_ev_inc, w_ev_tick;
  logic w_run, w_set_h, w_set_m, w_set;
  logic w_sec_inc, w_sec_clr, w_min_inc, w_hr_inc;
  logic w_sec_wrap, w_min_wrap, w_hr_wrap;
  logic [3:0] w_sec_t, w_sec_o, w_min_t, w_min_o, w_hr_t, w_hr_o;

  // A mode change swallows any increment or tick in the same cycle
  assign w_ev_mode = i_en_all && i_key_mode;
  assign w_ev_inc  = i_en_all && i_key_inc && !i_key_mode;
  assign w_ev_tick = i_en_all && i_tick && !i_key_mode;

  assign w_run   = (r_mode == ModeRun);
  assign w_set_h = (r_mode == ModeSetH);
  assign w_set_m = (r_mode == ModeSetM);
  assign w_set   = w_set_h || w_set_m;

  assign w_sec_inc = w_run && w_ev_tick;
  assign w_sec_clr = w_run && w_ev_mode;
  assign w_min_inc = (w_run && w_sec_wrap) || (w_set_m && w_ev_inc);
  assign w_hr_inc  = (w_run && w_min_wrap) || (w_set_h && w_ev_inc);

  bcd_mod_counter #(.MAX(59)) u_sec (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (w_sec_inc),
    .i_clr  (w_sec_clr),
    .o_tens (w_sec_t),
    .o_ones (w_sec_o),
    .o_wrap (w_sec_wrap)
  );

  bcd_mod_counter #(.MAX(59)) u_min (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (w_min_inc),
    .i_clr  (1'b0),
    .o_tens (w_min_t),
    .o_ones (w_min_o),
    .o_wrap (w_min_wrap)
  );

  bcd_mod_counter #(.MAX(23)) u_hr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (w_hr_inc),
    .i_clr  (1'b0),
    .o_tens (w_hr_t),
    .o_ones (w_hr_o),
    .o_wrap (w_hr_wrap)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode      <= ModeRun;
      r_blink     <= 1'b0;
      r_day_pulse <= 1'b0;
    end else if (i_en_all) begin
      r_day_pulse <= w_run && w_hr_wrap;
      if (w_ev_mode) begin
        r_blink <= 1'b0;
        unique case (r_mode)
          ModeRun:  r_mode <= ModeSetH;
          ModeSetH: r_mode <= ModeSetM;
          ModeSetM: r_mode <= ModeRun;
          default:  r_mode <= ModeRun;
        endcase
      end else if (w_set && w_ev_inc) begin
        r_blink <= 1'b0;
      end else if (w_set && w_ev_tick) begin
        r_blink <= !r_blink;
      end
    end
  end

  always_comb begin
    o_digits = '0;
    o_digits[HrTensLsb  +: 4] = w_hr_t;
    o_digits[HrOnesLsb  +: 4] = w_hr_o;
    o_digits[DashHiLsb  +: 4] = DASH_CODE;
    o_digits[MinTensLsb +: 4] = w_min_t;
    o_digits[MinOnesLsb +: 4] = w_min_o;
    o_digits[DashLoLsb  +: 4] = DASH_CODE;
    o_digits[SecTensLsb +: 4] = w_sec_t;
    o_digits[SecOnesLsb +: 4] = w_sec_o;
  end

  always_comb begin
    o_blank_mask = BlankNone;
    if (r_blink && w_set_h) o_blank_mask = BlankSetH;
    if (r_blink && w_set_m) o_blank_mask = BlankSetM;
  end

  assign o_day_pulse = r_day_pulse;
  assign o_mode      = r_mode;

endmodule

// File: tb/tb_time_bcd_counter.sv
// Directed bench for time_bcd_counter with hand-computed expected values.
module tb_time_bcd_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_all = 1'b0;
  logic        tick = 1'b0;
  logic        key_mode = 1'b0;
  logic        key_inc = 1'b0;
  logic [31:0] digits;
  logic [7:0]  blank_mask;
  logic        day_pulse;
  logic [1:0]  mode;

  int n_cmp = 0;
  int n_err = 0;
  int dp_seen = 0;

  time_bcd_counter #(.DASH_CODE(4'hA)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en_all     (en_all),
    .i_tick       (tick),
    .i_key_mode   (key_mode),
    .i_key_inc    (key_inc),
    .o_digits     (digits),
    .o_blank_mask (blank_mask),
    .o_day_pulse  (day_pulse),
    .o_mode       (mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge, then sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
    if (day_pulse) dp_seen++;
  endtask

  task automatic pulse(input logic t, input logic km, input logic ki);
    tick = t; key_mode = km; key_inc = ki;
    step();
    tick = 1'b0; key_mode = 1'b0; key_inc = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 1'b0);
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int deviations;

    rst = 1'b1;
    step();
    rst = 1'b0;
    check("reset_digits", digits, 32'h00A00A00);
    check("reset_mode", {30'd0, mode}, 32'd0);
    check("reset_blank", {24'd0, blank_mask}, 32'd0);
    check("reset_day", {31'd0, day_pulse}, 32'd0);

    en_all = 1'b1;
    dp_seen = 0;
    ticks(61);
    check("run_61_ticks", digits, 32'h00A01A01);
    check("run_no_day_pulse", dp_seen, 0);

    // Preload 23:59:58
    pulse(1'b0, 1'b1, 1'b0);
    incs(23);
    check("set_h_23", digits, 32'h23A01A00);
    pulse(1'b0, 1'b1, 1'b0);
    incs(58);
    pulse(1'b0, 1'b1, 1'b0);
    check("back_to_run", {30'd0, mode}, 32'd0);
    ticks(58);
    check("preload", digits, 32'h23A59A58);
    dp_seen = 0;
    ticks(1);
    check("t_235959", digits, 32'h23A59A59);
    check("no_pulse_235959", {31'd0, day_pulse}, 32'd0);
    ticks(1);
    check("rollover", digits, 32'h00A00A00);
    check("day_pulse_hi", {31'd0, day_pulse}, 32'd1);
    step();
    check("day_pulse_lo", {31'd0, day_pulse}, 32'd0);
    check("day_pulse_once", dp_seen, 1);

    ticks(37);
    check("run_37", digits, 32'h00A00A37);
    pulse(1'b0, 1'b1, 1'b0);
    check("enter_set_h", {30'd0, mode}, 32'd1);
    check("sec_cleared", digits, 32'h00A00A00);
    dp_seen = 0;
    incs(25);
    check("hr_25_incs", digits, 32'h01A00A00);
    pulse(1'b0, 1'b1, 1'b0);
    check("enter_set_m", {30'd0, mode}, 32'd2);
    incs(60);
    check("min_60_incs", digits, 32'h01A00A00);
    check("set_no_day_pulse", dp_seen, 0);

    ticks(1);
    check("blink_1", {24'd0, blank_mask}, 32'h18);
    ticks(1);
    check("blink_2", {24'd0, blank_mask}, 32'h00);
    ticks(1);
    check("blink_3", {24'd0, blank_mask}, 32'h18);
    pulse(1'b0, 1'b0, 1'b1);
    check("inc_clears_blink", {24'd0, blank_mask}, 32'h00);
    check("inc_min", digits, 32'h01A01A00);
    ticks(1);
    check("blink_4", {24'd0, blank_mask}, 32'h18);
    check("set_no_advance", digits, 32'h01A01A00);
    pulse(1'b1, 1'b0, 1'b1);
    check("inc_tick_blank", {24'd0, blank_mask}, 32'h00);
    check("inc_tick_digits", digits, 32'h01A02A00);

    en_all = 1'b0;
    deviations = 0;
    for (int i = 0; i < 100; i++) begin
      pulse(i[0], i[1], i[2] | i[3]);
      if (digits !== 32'h01A02A00 || mode !== 2'd2 || blank_mask !== 8'h00 || day_pulse !== 1'b0)
        deviations++;
    end
    check("freeze_deviations", deviations, 0);
    en_all = 1'b1;

    pulse(1'b0, 1'b1, 1'b0);
    check("set_m_to_run", {30'd0, mode}, 32'd0);
    ticks(3);
    check("run_3", digits, 32'h01A02A03);
    pulse(1'b1, 1'b1, 1'b0);
    check("mode_tick_mode", {30'd0, mode}, 32'd1);
    check("mode_tick_digits", digits, 32'h01A02A00);
    pulse(1'b0, 1'b1, 1'b1);
    check("mode_inc_mode", {30'd0, mode}, 32'd2);
    check("mode_inc_digits", digits, 32'h01A02A00);

    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("back_set_h", {30'd0, mode}, 32'd1);
    ticks(1);
    check("blink_h", {24'd0, blank_mask}, 32'hC0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mode", {30'd0, mode}, 32'd0);
    check("rst_digits", digits, 32'h00A00A00);
    check("rst_blank", {24'd0, blank_mask}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
